ex_div: RTL

- Iterative 32-bit divider instantiated inside the EX stage. Serves DIV/DIVU.
- Computes quotient and remainder by radix-2 shift-subtract, one quotient bit per cycle.
- While it is busy, EX raises its stall request. This holds stall[3]=Stop, so the EX/MEM register inserts bubbles downstream.
- On completion, EX forwards result_o as ex_hi (remainder) and ex_lo (quotient), with ex_hi_we=ex_lo_we=1, into EX/MEM.

---
 rtl/ex_div.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit radix-2 shift-subtract divider for the EX stage.
// Produces {remainder, quotient} for DIV (signed) and DIVU (unsigned).
// One quotient bit per cycle; a nonzero divisor takes 34 edges to ready_o,
// a zero divisor takes 2 edges and returns an all-zero result.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Working register: [64:33] partial remainder, [32:1] dividend/quotient bits.
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        quot_neg_q, quot_neg_d;
    logic        rem_neg_q, rem_neg_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    // Operand magnitudes; only negated in signed mode.
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    // Trial subtraction and final sign-corrected results.
    logic [32:0] diff;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign dividend_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign divisor_abs  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    assign diff     = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign quot_raw = work_q[31:0];
    assign rem_raw  = work_q[64:33];
    assign quot_fix = quot_neg_q ? (~quot_raw + 32'd1) : quot_raw;
    assign rem_fix  = rem_neg_q  ? (~rem_raw  + 32'd1) : rem_raw;

    // State register; synchronous reset clears control, result and working data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FREE;
            cnt_q      <= 6'd0;
            work_q     <= 65'd0;
            divisor_q  <= 32'd0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic: operand capture, iteration, sign fix-up and handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = 64'd0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d    = ON;
                        cnt_d      = 6'd0;
                        work_d     = {32'd0, dividend_abs, 1'b0};
                        divisor_d  = divisor_abs;
                        // Latch sign decisions now; operand inputs are free to change.
                        quot_neg_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        rem_neg_d  = signed_div_i && opdata1_i[31];
                    end
                end
            end
            BYZERO: begin
                state_d  = END;
                work_d   = 65'd0;
                result_d = 64'd0;
                ready_d  = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                    cnt_d   = 6'd0;
                    work_d  = 65'd0;
                end else if (cnt_q != 6'd32) begin
                    if (diff[32]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {diff[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    cnt_d    = 6'd0;
                    state_d  = END;
                end
            end
            END: begin
                // Hold the result until EX drops start_i after consuming it.
                if (!start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = 64'd0;
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
